hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. Drives the enable (as stall, active-high, enable = ~stall) and clr (flush) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Also produces forwarding selects and sequences the multi-cycle divider. Resolves load-use, branch-operand, divider-busy, data-memory-wait and exception hazards under a fixed priority.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_ctrl_div_seq.sv | 77 +++++++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the MIPS hazard controller.
// Divider FSM states, forwarding selects, stall/flush bundle.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic stallM;
    logic stallW;
    logic flushD;
    logic flushE;
    logic flushM;
    logic flushW;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_div_seq.sv
// Multi-cycle divider sequencer: IDLE -> BUSY -> DONE.
// In: divE, exceptM, memstall. Out: div_start, div_busy, state.
module div_seq
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       divE,
  input  logic       exceptM,
  input  logic       memstall,
  output logic       div_start,
  output logic       div_busy,
  output div_state_e state
);

  localparam int CW =
    (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(DIV_CYCLES - 1);

  div_state_e    state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (divE) begin
          state_d   = BUSY;
          cnt_d     = CNT_LOAD;
          div_start = 1'b1;
        end
      end
      BUSY: begin
        // counter also runs while memory stalls
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        // divE ignored: the finished div is still in E
        if (!memstall) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (exceptM) begin
      state_d   = IDLE;
      cnt_d     = '0;
      div_start = 1'b0;
    end
  end

  assign div_busy = (state_q == BUSY) | div_start;
  assign state    = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, stall/flush priority.
// Ports: D/E/M/W register ids and controls in; fwd, stall, flush, div out.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int REG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rtE,
  input  logic [REG_W-1:0] writeregE,
  input  logic [REG_W-1:0] writeregM,
  input  logic [REG_W-1:0] writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             branchD,
  input  logic             divE,
  input  logic             memreqM,
  input  logic             memackM,
  input  logic             exceptM,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             stallW,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic             div_start,
  output logic             div_busy
);

  function automatic logic hit(
    input logic             we,
    input logic [REG_W-1:0] wr,
    input logic [REG_W-1:0] src
  );
    return we && (wr != '0) && (wr == src);
  endfunction

  div_state_e div_state;
  logic       div_start_w;
  logic       div_busy_w;

  logic hm_rsE, hw_rsE, hm_rtE, hw_rtE;
  logic hm_rsD, hm_rtD, he_rsD, he_rtD;
  logic memstall, lwstall, brstall;
  logic [1:0] fae, fbe;
  logic [3:0] sel;
  hz_ctrl_t   hz;

  assign hm_rsE = hit(regwriteM, writeregM, rsE);
  assign hw_rsE = hit(regwriteW, writeregW, rsE);
  assign hm_rtE = hit(regwriteM, writeregM, rtE);
  assign hw_rtE = hit(regwriteW, writeregW, rtE);
  assign hm_rsD = hit(regwriteM, writeregM, rsD);
  assign hm_rtD = hit(regwriteM, writeregM, rtD);
  assign he_rsD = hit(regwriteE, writeregE, rsD);
  assign he_rtD = hit(regwriteE, writeregE, rtD);

  assign memstall = memreqM & ~memackM;
  assign lwstall  = memtoregE & (he_rsD | he_rtD);
  assign brstall  = branchD &
    ((he_rsD | he_rtD) |
     (memtoregM & (hm_rsD | hm_rtD)));

  div_seq #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .divE     (divE),
    .exceptM  (exceptM),
    .memstall (memstall),
    .div_start(div_start_w),
    .div_busy (div_busy_w),
    .state    (div_state)
  );

  // M is the younger result, so it wins over W
  always_comb begin
    fae = FWD_RF;
    fbe = FWD_RF;
    if (hm_rsE)      fae = FWD_M;
    else if (hw_rsE) fae = FWD_W;
    if (hm_rtE)      fbe = FWD_M;
    else if (hw_rtE) fbe = FWD_W;
  end

  // one-hot priority select, highest first
  assign sel[3] = exceptM;
  assign sel[2] = memstall & ~exceptM;
  assign sel[1] = div_busy_w & ~exceptM & ~memstall;
  assign sel[0] = (lwstall | brstall) &
                  ~(exceptM | memstall | div_busy_w);

  always_comb begin
    hz = '0;
    unique case (1'b1)
      sel[3]: begin
        hz.flushD = 1'b1;
        hz.flushE = 1'b1;
        hz.flushM = 1'b1;
        hz.flushW = 1'b1;
      end
      sel[2]: begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.stallE = 1'b1;
        hz.stallM = 1'b1;
        hz.flushW = 1'b1;
      end
      sel[1]: begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.stallE = 1'b1;
        hz.flushM = 1'b1;
      end
      sel[0]: begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.flushE = 1'b1;
      end
      default: hz = '0;
    endcase
  end

  // everything is forced quiet while reset is held
  assign forwardAD = hm_rsD & ~rst;
  assign forwardBD = hm_rtD & ~rst;
  assign forwardAE = fae & {2{~rst}};
  assign forwardBE = fbe & {2{~rst}};
  assign stallF    = hz.stallF & ~rst;
  assign stallD    = hz.stallD & ~rst;
  assign stallE    = hz.stallE & ~rst;
  assign stallM    = hz.stallM & ~rst;
  assign stallW    = hz.stallW & ~rst;
  assign flushD    = hz.flushD & ~rst;
  assign flushE    = hz.flushE & ~rst;
  assign flushM    = hz.flushM & ~rst;
  assign flushW    = hz.flushW & ~rst;
  assign div_start = div_start_w & ~rst;
  assign div_busy  = div_busy_w & ~rst;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (DIV_CYCLES=4).
// Vector table for combinational paths, sequences for the divider.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic [4:0] writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW;
  logic       memtoregE, memtoregM, branchD, divE;
  logic       memreqM, memackM, exceptM;
  logic       forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushD, flushE, flushM, flushW;
  logic       div_start, div_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .DIV_CYCLES(4),
    .REG_W     (5)
  ) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM),
    .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM),
    .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .divE(divE),
    .memreqM(memreqM), .memackM(memackM),
    .exceptM(exceptM),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .stallM(stallM), .stallW(stallW),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .flushW(flushW),
    .div_start(div_start), .div_busy(div_busy)
  );

  logic [5:0]  fwd_v;
  logic [4:0]  stl_v;
  logic [3:0]  fl_v;
  logic [16:0] all_v;
  assign fwd_v = {forwardAD, forwardBD, forwardAE, forwardBE};
  assign stl_v = {stallF, stallD, stallE, stallM, stallW};
  assign fl_v  = {flushD, flushE, flushM, flushW};
  assign all_v = {fwd_v, stl_v, fl_v, div_start, div_busy};

  typedef struct packed {
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic       rwE, rwM, rwW, mtrE, mtrM, brD;
    logic       mreq, mack, exc;
    logic [5:0] fwd;
    logic [4:0] stl;
    logic [3:0] fl;
  } vec_t;

  vec_t vq[$];
  vec_t v;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeregE = '0; writeregM = '0; writeregW = '0;
    regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
    memtoregE = 1'b0; memtoregM = 1'b0; branchD = 1'b0;
    divE = 1'b0; memreqM = 1'b0; memackM = 1'b0;
    exceptM = 1'b0;
  endtask

  task automatic chk_st(input string nm, input div_state_e s);
    chk(nm, 32'(dut.div_state), 32'(s));
  endtask

  initial begin
    // forwarding
    v = '0; vq.push_back(v);
    v = '0; v.rwM = 1; v.wrM = 8; v.rsE = 8;
    v.rwW = 1; v.wrW = 8; v.fwd = 6'b001000; vq.push_back(v);
    v.wrM = 0; v.fwd = 6'b000100; vq.push_back(v);
    v = '0; v.rtE = 5; v.rwW = 1; v.wrW = 5;
    v.rwM = 1; v.wrM = 6; v.fwd = 6'b000001; vq.push_back(v);
    v = '0; v.rsD = 7; v.rtD = 3; v.rwM = 1; v.wrM = 3;
    v.fwd = 6'b010000; vq.push_back(v);
    v = '0; v.rsE = 8; v.rtE = 8; v.wrW = 8; v.wrM = 8;
    vq.push_back(v);
    v = '0; v.rwM = 1; v.wrM = 2; v.rsE = 2; v.rtE = 3;
    v.rwW = 1; v.wrW = 3; v.rsD = 2;
    v.fwd = 6'b101001; vq.push_back(v);
    // load-use
    v = '0; v.mtrE = 1; v.rwE = 1; v.wrE = 9; v.rtD = 9;
    v.stl = 5'b11000; v.fl = 4'b0100; vq.push_back(v);
    v = '0; v.mtrE = 1; v.rwE = 1; vq.push_back(v);
    v = '0; v.mtrE = 1; v.wrE = 9; v.rtD = 9; vq.push_back(v);
    // branch operands
    v = '0; v.brD = 1; v.rwE = 1; v.wrE = 4; v.rsD = 4;
    v.stl = 5'b11000; v.fl = 4'b0100; vq.push_back(v);
    v = '0; v.brD = 1; v.mtrM = 1; v.rwM = 1; v.wrM = 12;
    v.rtD = 12; v.fwd = 6'b010000;
    v.stl = 5'b11000; v.fl = 4'b0100; vq.push_back(v);
    v = '0; v.brD = 1; v.rwM = 1; v.wrM = 12; v.rtD = 12;
    v.fwd = 6'b010000; vq.push_back(v);
    // memory wait and priority
    v = '0; v.mreq = 1; v.stl = 5'b11110; v.fl = 4'b0001;
    vq.push_back(v);
    v = '0; v.mreq = 1; v.mack = 1; vq.push_back(v);
    v = '0; v.mreq = 1; v.mtrE = 1; v.rwE = 1; v.wrE = 9;
    v.rsD = 9; v.stl = 5'b11110; v.fl = 4'b0001;
    vq.push_back(v);
    v.exc = 1; v.stl = 5'b00000; v.fl = 4'b1111;
    vq.push_back(v);

    // reset: outputs quiet even with active inputs
    clear_in();
    rst = 1'b1;
    divE = 1'b1; memreqM = 1'b1; regwriteM = 1'b1;
    writeregM = 5'd8; rsE = 5'd8; rsD = 5'd8;
    #3;
    chk("rst_outputs", 32'(all_v), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_outputs2", 32'(all_v), 32'd0);
    chk_st("rst_state", IDLE);
    @(negedge clk);
    clear_in();
    rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      clear_in();
      rsD = vq[i].rsD; rtD = vq[i].rtD;
      rsE = vq[i].rsE; rtE = vq[i].rtE;
      writeregE = vq[i].wrE; writeregM = vq[i].wrM;
      writeregW = vq[i].wrW;
      regwriteE = vq[i].rwE; regwriteM = vq[i].rwM;
      regwriteW = vq[i].rwW;
      memtoregE = vq[i].mtrE; memtoregM = vq[i].mtrM;
      branchD = vq[i].brD; memreqM = vq[i].mreq;
      memackM = vq[i].mack; exceptM = vq[i].exc;
      #1;
      chk($sformatf("vec%0d_fwd", i), 32'(fwd_v), 32'(vq[i].fwd));
      chk($sformatf("vec%0d_stall", i), 32'(stl_v), 32'(vq[i].stl));
      chk($sformatf("vec%0d_flush", i), 32'(fl_v), 32'(vq[i].fl));
    end

    // divide: start + 4 BUSY cycles held, one DONE, then IDLE
    for (int c = 0; c < 7; c++) begin
      div_state_e es;
      @(negedge clk);
      clear_in();
      divE = (c < 6);
      #1;
      es = (c == 0) ? IDLE : (c < 5) ? BUSY : (c == 5) ? DONE : IDLE;
      chk($sformatf("divA%0d_start", c), 32'(div_start), 32'(c == 0));
      chk($sformatf("divA%0d_busy", c), 32'(div_busy), 32'(c < 5));
      chk($sformatf("divA%0d_stall", c), 32'(stl_v),
          (c < 5) ? 32'h1C : 32'h0);
      chk($sformatf("divA%0d_flush", c), 32'(fl_v),
          (c < 5) ? 32'h2 : 32'h0);
      chk_st($sformatf("divA%0d_state", c), es);
    end

    // memstall in BUSY and across DONE; no restart
    for (int c = 0; c < 10; c++) begin
      div_state_e es;
      logic ms;
      @(negedge clk);
      clear_in();
      ms = (c == 2) || (c >= 5 && c <= 7);
      divE = (c <= 8);
      memreqM = ms || (c == 8);
      memackM = (c == 8);
      #1;
      es = (c == 0) ? IDLE : (c < 5) ? BUSY : (c < 9) ? DONE : IDLE;
      chk($sformatf("divB%0d_start", c), 32'(div_start), 32'(c == 0));
      chk($sformatf("divB%0d_stall", c), 32'(stl_v),
          ms ? 32'h1E : (c < 5) ? 32'h1C : 32'h0);
      chk($sformatf("divB%0d_flush", c), 32'(fl_v),
          ms ? 32'h1 : (c < 5) ? 32'h2 : 32'h0);
      chk_st($sformatf("divB%0d_state", c), es);
    end

    // exception during BUSY
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      clear_in();
      divE = (c < 4);
      exceptM = (c == 3);
      #1;
      if (c == 3) begin
        chk("divC_flush", 32'(fl_v), 32'hF);
        chk("divC_stall", 32'(stl_v), 32'h0);
        chk("divC_start", 32'(div_start), 32'd0);
      end
      if (c == 4) begin
        chk_st("divC_state", IDLE);
        chk("divC_busy", 32'(div_busy), 32'd0);
      end
    end

    // exception together with divE in IDLE
    @(negedge clk);
    clear_in();
    divE = 1'b1; exceptM = 1'b1;
    #1;
    chk("divD_start", 32'(div_start), 32'd0);
    chk("divD_flush", 32'(fl_v), 32'hF);
    @(negedge clk);
    clear_in();
    #1;
    chk_st("divD_state", IDLE);
    chk("divD_busy", 32'(div_busy), 32'd0);

    // reset pulse mid-BUSY
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      clear_in();
      rst = (c == 3) || (c == 4);
      divE = (c < 5) || (c == 6);
      if (rst) begin
        memreqM = 1'b1; regwriteM = 1'b1;
        writeregM = 5'd3; rtE = 5'd3; rtD = 5'd3;
      end
      #1;
      if (c == 2) chk_st("divE_busy_state", BUSY);
      if (rst) chk($sformatf("divE%0d_rst_out", c), 32'(all_v), 32'd0);
      if (c == 5) begin
        chk_st("divE_state", IDLE);
        chk("divE_start", 32'(div_start), 32'd0);
        chk("divE_busy", 32'(div_busy), 32'd0);
      end
      if (c == 6) chk("divE_restart", 32'(div_start), 32'd1);
    end

    @(negedge clk);
    clear_in();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
